// File: rtl/cordic_post_scaler.sv
// Purpose: removes CORDIC gain from vectoring-mode x (round-half-up, saturate) and buffers results in a show-ahead FIFO.
// Latency: input sampled at edge N is visible on the outputs after edge N+2 (empty FIFO); one result per clock.
// Backpressure: the input cannot be stalled; i_out_ready drains the FIFO, and a write into a full FIFO is dropped and flagged.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_valid, i_x/y/z          CORDIC result stream (signed Q INTEGER_BITS.FRACTIONAL_BITS)
//   i_mode, i_rot_en          2-bit signed mode (-1 hyp, 0 lin, 1 circ), rotation flag
//   i_out_ready               consumer ready
//   o_valid, o_x/y/z          FIFO head (all data/flags forced to 0 when o_valid = 0)
//   o_mode, o_rot_en, o_sat   carried flags and per-result saturation flag
//   o_overflow, o_count       sticky drop flag, FIFO occupancy
module cordic_post_scaler #(
    parameter int INTEGER_BITS    = 3,
    parameter int FRACTIONAL_BITS = 30,
    parameter int COEF_FRAC       = 30,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_valid,
    input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] i_x,
    input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] i_y,
    input  logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] i_z,
    input  logic [1:0]                              i_mode,
    input  logic                                    i_rot_en,
    input  logic                                    i_out_ready,
    output logic                                    o_valid,
    output logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] o_x,
    output logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] o_y,
    output logic [INTEGER_BITS+FRACTIONAL_BITS-1:0] o_z,
    output logic [1:0]                              o_mode,
    output logic                                    o_rot_en,
    output logic                                    o_sat,
    output logic                                    o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]             o_count
);

    localparam int W    = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int CW   = COEF_FRAC + 2;
    localparam int PW   = W + CW;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;

    // Gain-removal coefficients, unsigned Q2.COEF_FRAC. $rtoi limits COEF_FRAC to 30.
    localparam logic [CW-1:0] C_CIRC = CW'($rtoi(0.6072529350 * (2.0 ** COEF_FRAC) + 0.5));
    localparam logic [CW-1:0] C_HYP  = CW'($rtoi(1.2074970678 * (2.0 ** COEF_FRAC) + 0.5));

    localparam logic signed [PW-1:0] HALF  = {{(PW-COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC-1){1'b0}}};
    localparam logic signed [PW-1:0] SMAX  = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN  = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
        logic [1:0]   mode;
        logic         rot_en;
        logic         sat;
    } ent_t;

    // ---------------- stage 1: capture and coefficient select ----------------
    logic          s1_vld_q, s1_vld_d;
    logic [W-1:0]  s1_x_q, s1_x_d, s1_y_q, s1_y_d, s1_z_q, s1_z_d;
    logic [1:0]    s1_mode_q, s1_mode_d;
    logic          s1_rot_q, s1_rot_d;
    logic [CW-1:0] s1_coef_q, s1_coef_d;
    logic          s1_byp_q, s1_byp_d;

    always_comb begin
        s1_vld_d  = i_valid;
        s1_x_d    = s1_x_q;
        s1_y_d    = s1_y_q;
        s1_z_d    = s1_z_q;
        s1_mode_d = s1_mode_q;
        s1_rot_d  = s1_rot_q;
        s1_coef_d = s1_coef_q;
        s1_byp_d  = s1_byp_q;
        if (i_valid) begin
            s1_x_d    = i_x;
            s1_y_d    = i_y;
            s1_z_d    = i_z;
            s1_mode_d = i_mode;
            s1_rot_d  = i_rot_en;
            s1_coef_d = '0;
            s1_byp_d  = 1'b1;
            // Only vectoring results carry the gain; 2'b10 is not a real mode and is bypassed.
            if (!i_rot_en && i_mode == 2'b01) begin
                s1_coef_d = C_CIRC;
                s1_byp_d  = 1'b0;
            end else if (!i_rot_en && i_mode == 2'b11) begin
                s1_coef_d = C_HYP;
                s1_byp_d  = 1'b0;
            end
        end
    end

    // ---------------- stage 2: full-precision product ----------------
    logic                 s2_vld_q, s2_vld_d;
    logic signed [PW-1:0] s2_p_q, s2_p_d;
    logic [W-1:0]         s2_x_q, s2_x_d, s2_y_q, s2_y_d, s2_z_q, s2_z_d;
    logic [1:0]           s2_mode_q, s2_mode_d;
    logic                 s2_rot_q, s2_rot_d;
    logic                 s2_byp_q, s2_byp_d;

    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_p_d    = s2_p_q;
        s2_x_d    = s2_x_q;
        s2_y_d    = s2_y_q;
        s2_z_d    = s2_z_q;
        s2_mode_d = s2_mode_q;
        s2_rot_d  = s2_rot_q;
        s2_byp_d  = s2_byp_q;
        if (s1_vld_q) begin
            // Signed x times unsigned coefficient: zero-extend C so it stays positive.
            s2_p_d    = $signed({{(PW-W){s1_x_q[W-1]}}, s1_x_q}) *
                        $signed({{(PW-CW){1'b0}}, s1_coef_q});
            s2_x_d    = s1_x_q;
            s2_y_d    = s1_y_q;
            s2_z_d    = s1_z_q;
            s2_mode_d = s1_mode_q;
            s2_rot_d  = s1_rot_q;
            s2_byp_d  = s1_byp_q;
        end
    end

    // ---------------- stage 3: round half-up, saturate (combinational into FIFO) ----------------
    logic signed [PW-1:0] p_rnd;
    logic signed [PW-1:0] r_full;
    ent_t                 s3_ent;

    always_comb begin
        p_rnd  = s2_p_q + HALF;
        r_full = p_rnd >>> COEF_FRAC;
        s3_ent = '0;
        s3_ent.y      = s2_y_q;
        s3_ent.z      = s2_z_q;
        s3_ent.mode   = s2_mode_q;
        s3_ent.rot_en = s2_rot_q;
        if (s2_byp_q) begin
            s3_ent.x = s2_x_q;
        end else if (r_full > SMAX) begin
            s3_ent.x   = SMAX[W-1:0];
            s3_ent.sat = 1'b1;
        end else if (r_full < SMIN) begin
            s3_ent.x   = SMIN[W-1:0];
            s3_ent.sat = 1'b1;
        end else begin
            s3_ent.x = r_full[W-1:0];
        end
    end

    // ---------------- show-ahead FIFO ----------------
    ent_t            mem_q [FIFO_DEPTH];
    ent_t            mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            pop, push, full;

    always_comb begin
        full = (count_q == CNTW'(FIFO_DEPTH));
        pop  = (count_q != '0) && i_out_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts the write.
        push = s2_vld_q && (!full || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q | (s2_vld_q && full && !pop);
        count_d  = count_q + CNTW'(push) - CNTW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = s3_ent;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_q  <= 1'b0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_z_q    <= '0;
            s1_mode_q <= '0;
            s1_rot_q  <= 1'b0;
            s1_coef_q <= '0;
            s1_byp_q  <= 1'b1;
            s2_vld_q  <= 1'b0;
            s2_p_q    <= '0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
            s2_z_q    <= '0;
            s2_mode_q <= '0;
            s2_rot_q  <= 1'b0;
            s2_byp_q  <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_x_q    <= s1_x_d;
            s1_y_q    <= s1_y_d;
            s1_z_q    <= s1_z_d;
            s1_mode_q <= s1_mode_d;
            s1_rot_q  <= s1_rot_d;
            s1_coef_q <= s1_coef_d;
            s1_byp_q  <= s1_byp_d;
            s2_vld_q  <= s2_vld_d;
            s2_p_q    <= s2_p_d;
            s2_x_q    <= s2_x_d;
            s2_y_q    <= s2_y_d;
            s2_z_q    <= s2_z_d;
            s2_mode_q <= s2_mode_d;
            s2_rot_q  <= s2_rot_d;
            s2_byp_q  <= s2_byp_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // ---------------- outputs ----------------
    ent_t head;

    always_comb begin
        head       = mem_q[rd_ptr_q];
        o_valid    = (count_q != '0);
        o_count    = count_q;
        o_overflow = ovf_q;
        o_x        = o_valid ? head.x      : '0;
        o_y        = o_valid ? head.y      : '0;
        o_z        = o_valid ? head.z      : '0;
        o_mode     = o_valid ? head.mode   : '0;
        o_rot_en   = o_valid ? head.rot_en : 1'b0;
        o_sat      = o_valid ? head.sat    : 1'b0;
    end

endmodule
